// File: rtl/gpio_stream_bridge.sv
// Purpose : word<->beat bridge between the wide internal stream and the narrow GPIO pin FIFOs.
// Latency : TX accepts a word then emits LANES beats back to back; RX raises rx_valid one cycle after the last beat.
// Backpressure: TX stalls in place while in_fifo_wfull_n is low; RX stops dequeuing while a word is held unconsumed.
//
// Ports:
//   io_clk, io_rst      sole clock, asynchronous active-high reset
//   clr                 synchronous abort of both paths (wins over everything else that cycle)
//   tx_valid/tx_ready/tx_data            word input (DATA_WIDTH*LANES bits)
//   in_fifo_wenq/in_fifo_wdata/in_fifo_wfull_n   beat output towards the pin FIFO
//   out_fifo_deq/out_fifo_rdata/out_fifo_rempty_n beat input from the pin FIFO (first-word fall-through)
//   rx_valid/rx_ready/rx_data/rx_err     reassembled word output
//
// Optional: define GPIO_STREAM_CHECKSUM_EN to append an XOR-of-lanes beat to every word
// on TX and to check it on RX (rx_err). Without it rx_err is tied low.
module gpio_stream_bridge #(
  parameter int DATA_WIDTH = 11,
  parameter int LANES      = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          io_clk,
  input  logic                          io_rst,
  input  logic                          clr,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_WIDTH*LANES-1:0]   tx_data,
  output logic                          in_fifo_wenq,
  output logic [DATA_WIDTH-1:0]         in_fifo_wdata,
  input  logic                          in_fifo_wfull_n,
  output logic                          out_fifo_deq,
  input  logic [DATA_WIDTH-1:0]         out_fifo_rdata,
  input  logic                          out_fifo_rempty_n,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [DATA_WIDTH*LANES-1:0]   rx_data,
  output logic                          rx_err
);

  localparam int W  = DATA_WIDTH * LANES;
  // Wide enough to count LANES+1 beats (word plus optional checksum beat).
  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);
`ifdef GPIO_STREAM_CHECKSUM_EN
  localparam logic [CW-1:0] RX_LAST = CW'(LANES);
`else
  localparam logic [CW-1:0] RX_LAST = LAST;
`endif

`ifdef GPIO_STREAM_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] lane_xor(input logic [W-1:0] w);
    logic [DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++) acc = acc ^ w[i*DATA_WIDTH +: DATA_WIDTH];
    return acc;
  endfunction
`endif

  // ---------------------------------------------------------------- TX path
`ifdef GPIO_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CSUM} tx_state_t;
  logic [DATA_WIDTH-1:0] tx_csum;
`else
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
`endif

  tx_state_t             tx_state, tx_state_nxt;
  logic [W-1:0]          tx_shift;
  logic [CW-1:0]         tx_cnt;
  logic [DATA_WIDTH-1:0] tx_head;

  // The outgoing lane always sits at one end of the shift register; shifting
  // zeros in means the beat bus reads 0 once the word has fully drained.
  assign tx_head = MSB_FIRST ? tx_shift[W-1 -: DATA_WIDTH] : tx_shift[DATA_WIDTH-1:0];

  always_comb begin
    tx_state_nxt  = tx_state;
    tx_ready      = 1'b0;
    in_fifo_wenq  = 1'b0;
    in_fifo_wdata = tx_head;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) tx_state_nxt = TX_SEND;
      end
      TX_SEND: begin
        // Beats are not pushed during an abort so the pin FIFO never sees half a word's tail.
        in_fifo_wenq = in_fifo_wfull_n & ~clr;
        if (in_fifo_wenq && tx_cnt == LAST) begin
`ifdef GPIO_STREAM_CHECKSUM_EN
          tx_state_nxt = TX_CSUM;
`else
          tx_state_nxt = TX_IDLE;
`endif
        end
      end
`ifdef GPIO_STREAM_CHECKSUM_EN
      TX_CSUM: begin
        in_fifo_wdata = tx_csum;
        in_fifo_wenq  = in_fifo_wfull_n & ~clr;
        if (in_fifo_wenq) tx_state_nxt = TX_IDLE;
      end
`endif
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
`ifdef GPIO_STREAM_CHECKSUM_EN
      tx_csum  <= '0;
`endif
    end else if (clr) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
`ifdef GPIO_STREAM_CHECKSUM_EN
      tx_csum  <= '0;
`endif
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == TX_IDLE && tx_valid) begin
        tx_shift <= tx_data;
        tx_cnt   <= '0;
`ifdef GPIO_STREAM_CHECKSUM_EN
        tx_csum  <= lane_xor(tx_data);
`endif
      end else if (tx_state == TX_SEND && in_fifo_wenq) begin
        tx_shift <= MSB_FIRST ? (tx_shift << DATA_WIDTH) : (tx_shift >> DATA_WIDTH);
        tx_cnt   <= (tx_cnt == LAST) ? '0 : tx_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] rx_lane;

  // Reset and abort also mask the strobe so no beat is pulled from the pin FIFO and then dropped.
  assign out_fifo_deq = out_fifo_rempty_n & ~rx_valid & ~clr & ~io_rst;

  // A checksum-beat index maps outside 0..LANES-1 in both orders, so it never writes a lane.
  assign rx_lane = MSB_FIRST ? (LAST - rx_cnt) : rx_cnt;

`ifdef GPIO_STREAM_CHECKSUM_EN
  logic rx_err_q;
  assign rx_err = rx_err_q;
`else
  assign rx_err = 1'b0;
`endif

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      rx_cnt   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
`ifdef GPIO_STREAM_CHECKSUM_EN
      rx_err_q <= 1'b0;
`endif
    end else if (clr) begin
      rx_cnt   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
`ifdef GPIO_STREAM_CHECKSUM_EN
      rx_err_q <= 1'b0;
`endif
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
`ifdef GPIO_STREAM_CHECKSUM_EN
        rx_err_q <= 1'b0;
`endif
      end
      if (out_fifo_deq) begin
        for (int i = 0; i < LANES; i++) begin
          if (rx_lane == CW'(i)) rx_data[i*DATA_WIDTH +: DATA_WIDTH] <= out_fifo_rdata;
        end
        if (rx_cnt == RX_LAST) begin
          rx_cnt   <= '0;
          rx_valid <= 1'b1;
`ifdef GPIO_STREAM_CHECKSUM_EN
          rx_err_q <= (out_fifo_rdata != lane_xor(rx_data));
`endif
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_stream_bridge.sv
`timescale 1ns/1ps
module tb_gpio_stream_bridge;
  localparam int DW = 11;
  localparam int LN = 4;
  localparam int W  = DW * LN;

  logic io_clk = 1'b0;
  logic io_rst, clr;

  // dut0: LSB-first, pins driven/observed by the bench
  logic          tx_valid, tx_ready;
  logic [W-1:0]  tx_data;
  logic          in_fifo_wenq, in_fifo_wfull_n;
  logic [DW-1:0] in_fifo_wdata;
  logic          out_fifo_deq, out_fifo_rempty_n;
  logic [DW-1:0] out_fifo_rdata;
  logic          rx_valid, rx_ready, rx_err;
  logic [W-1:0]  rx_data;

  // dut1: MSB-first, TX pins looped straight back into RX pins
  logic          m_tx_valid, m_tx_ready;
  logic [W-1:0]  m_tx_data;
  logic          m_wenq, m_deq;
  logic [DW-1:0] m_wdata;
  logic          m_rx_valid, m_rx_ready, m_rx_err;
  logic [W-1:0]  m_rx_data;

  logic [DW-1:0] beat_q[$];
  logic [W-1:0]  word_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 io_clk = ~io_clk;

  gpio_stream_bridge #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(1'b0)) dut0 (
    .io_clk(io_clk), .io_rst(io_rst), .clr(clr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .in_fifo_wenq(in_fifo_wenq), .in_fifo_wdata(in_fifo_wdata), .in_fifo_wfull_n(in_fifo_wfull_n),
    .out_fifo_deq(out_fifo_deq), .out_fifo_rdata(out_fifo_rdata), .out_fifo_rempty_n(out_fifo_rempty_n),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_err(rx_err)
  );

  gpio_stream_bridge #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(1'b1)) dut1 (
    .io_clk(io_clk), .io_rst(io_rst), .clr(clr),
    .tx_valid(m_tx_valid), .tx_ready(m_tx_ready), .tx_data(m_tx_data),
    .in_fifo_wenq(m_wenq), .in_fifo_wdata(m_wdata), .in_fifo_wfull_n(1'b1),
    .out_fifo_deq(m_deq), .out_fifo_rdata(m_wdata), .out_fifo_rempty_n(m_wenq),
    .rx_valid(m_rx_valid), .rx_ready(m_rx_ready), .rx_data(m_rx_data), .rx_err(m_rx_err)
  );

  task automatic test_reset();
    io_rst = 1'b1; clr = 1'b0;
    tx_valid = 1'b0; tx_data = '0; in_fifo_wfull_n = 1'b1;
    out_fifo_rempty_n = 1'b1; out_fifo_rdata = 11'h123; rx_ready = 1'b0;
    m_tx_valid = 1'b0; m_tx_data = '0; m_rx_ready = 1'b1;
    @(negedge io_clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    n_checks++; if (in_fifo_wenq !== 1'b0) begin n_fail++; $display("FAIL reset_wenq got %b want 0", in_fifo_wenq); end
    n_checks++; if (in_fifo_wdata !== 11'h000) begin n_fail++; $display("FAIL reset_wdata got %h want 000", in_fifo_wdata); end
    n_checks++; if (out_fifo_deq !== 1'b0) begin n_fail++; $display("FAIL reset_deq got %b want 0", out_fifo_deq); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
    n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
    @(posedge io_clk); #1;
    io_rst = 1'b0; out_fifo_rempty_n = 1'b0;
  endtask

  // Sends one word on dut0; stall_len cycles of wfull_n low once stall_at beats have gone.
  task automatic test_tx(input logic [W-1:0] w, input int stall_at, input int stall_len);
    int enq, cyc, stalls, left;
    logic [DW-1:0] exp;
    enq = 0; cyc = 0; stalls = 0; left = stall_len;
    tx_valid = 1'b1; tx_data = w; in_fifo_wfull_n = 1'b1;
    @(negedge io_clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_idle got %b want 1", tx_ready); end
    @(posedge io_clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < LN; i++) beat_q.push_back(w[i*DW +: DW]);
    while (enq < LN && cyc < 50) begin
      if (enq == stall_at && left > 0) begin in_fifo_wfull_n = 1'b0; left--; end
      else in_fifo_wfull_n = 1'b1;
      @(negedge io_clk);
      n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_busy got %b want 0", tx_ready); end
      if (!in_fifo_wfull_n) begin
        stalls++;
        n_checks++; if (in_fifo_wenq !== 1'b0) begin n_fail++; $display("FAIL tx_stall_wenq got %b want 0", in_fifo_wenq); end
        if (beat_q.size() > 0) begin
          n_checks++; if (in_fifo_wdata !== beat_q[0]) begin n_fail++; $display("FAIL tx_stall_wdata got %h want %h", in_fifo_wdata, beat_q[0]); end
        end
      end else begin
        n_checks++; if (in_fifo_wenq !== 1'b1) begin n_fail++; $display("FAIL tx_wenq got %b want 1 (beat %0d)", in_fifo_wenq, enq); end
        if (in_fifo_wenq === 1'b1 && beat_q.size() > 0) begin
          exp = beat_q.pop_front();
          n_checks++; if (in_fifo_wdata !== exp) begin n_fail++; $display("FAIL tx_beat got %h want %h", in_fifo_wdata, exp); end
          enq++;
        end
      end
      @(posedge io_clk); #1;
      cyc++;
    end
    in_fifo_wfull_n = 1'b1;
    n_checks++; if (enq !== LN) begin n_fail++; $display("FAIL tx_timeout beats %0d want %0d", enq, LN); end
    n_checks++; if (cyc !== LN + stalls) begin n_fail++; $display("FAIL tx_cycles got %0d want %0d", cyc, LN + stalls); end
    @(negedge io_clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_return got %b want 1", tx_ready); end
    n_checks++; if (in_fifo_wenq !== 1'b0) begin n_fail++; $display("FAIL tx_extra_beat wenq got %b want 0", in_fifo_wenq); end
    @(posedge io_clk); #1;
  endtask

  // Feeds the lanes of w (lane 0 first) to dut0 RX, then holds the word for hold cycles.
  task automatic test_rx(input logic [W-1:0] w, input int hold);
    int i, cyc;
    logic [W-1:0] exp;
    i = 0; cyc = 0;
    word_q.push_back(w);
    while (i < LN && cyc < 50) begin
      out_fifo_rempty_n = 1'b1; out_fifo_rdata = w[i*DW +: DW];
      @(negedge io_clk);
      n_checks++; if (out_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL rx_deq got %b want 1 (beat %0d)", out_fifo_deq, i); end
      if (out_fifo_deq === 1'b1) i++;
      @(posedge io_clk); #1;
      cyc++;
    end
    out_fifo_rdata = 11'h5A5;   // next beat already waiting
    for (int k = 0; k < hold; k++) begin
      @(negedge io_clk);
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid_hold got %b want 1", rx_valid); end
      n_checks++; if (out_fifo_deq !== 1'b0) begin n_fail++; $display("FAIL rx_deq_hold got %b want 0", out_fifo_deq); end
      n_checks++; if (rx_data !== word_q[0]) begin n_fail++; $display("FAIL rx_data_hold got %h want %h", rx_data, word_q[0]); end
      @(posedge io_clk); #1;
    end
    rx_ready = 1'b1;
    @(negedge io_clk);
    exp = word_q.pop_front();
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL rx_word got v=%b %h want v=1 %h", rx_valid, rx_data, exp); end
    n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL rx_err got %b want 0", rx_err); end
    @(posedge io_clk); #1;
    rx_ready = 1'b0; out_fifo_rempty_n = 1'b0;
    @(negedge io_clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_drop got %b want 0", rx_valid); end
    @(posedge io_clk); #1;
  endtask

  task automatic test_msb_first(input logic [W-1:0] w);
    int cyc;
    logic [DW-1:0] eb;
    logic [W-1:0] ew;
    cyc = 0;
    for (int i = LN - 1; i >= 0; i--) beat_q.push_back(w[i*DW +: DW]);
    word_q.push_back(w);
    m_tx_valid = 1'b1; m_tx_data = w;
    @(negedge io_clk);
    n_checks++; if (m_tx_ready !== 1'b1) begin n_fail++; $display("FAIL msb_tx_ready got %b want 1", m_tx_ready); end
    @(posedge io_clk); #1;
    m_tx_valid = 1'b0;
    while (word_q.size() > 0 && cyc < 30) begin
      @(negedge io_clk);
      if (m_wenq === 1'b1 && beat_q.size() > 0) begin
        eb = beat_q.pop_front();
        n_checks++; if (m_wdata !== eb || m_deq !== 1'b1) begin n_fail++; $display("FAIL msb_beat got %h deq=%b want %h deq=1", m_wdata, m_deq, eb); end
      end
      if (m_rx_valid === 1'b1) begin
        ew = word_q.pop_front();
        n_checks++; if (m_rx_data !== ew || m_rx_err !== 1'b0) begin n_fail++; $display("FAIL msb_loopback got %h err=%b want %h err=0", m_rx_data, m_rx_err, ew); end
      end
      @(posedge io_clk); #1;
      cyc++;
    end
    n_checks++; if (word_q.size() != 0 || beat_q.size() != 0) begin n_fail++; $display("FAIL msb_timeout words left %0d beats left %0d want 0", word_q.size(), beat_q.size()); end
    word_q.delete(); beat_q.delete();
  endtask

  // Partial TX and RX words, then an abort (reset or clr); the next words must be clean.
  task automatic test_abort(input bit use_clr);
    tx_valid = 1'b1; tx_data = {11'h7AB, 11'h6CD, 11'h5EF, 11'h401};
    @(posedge io_clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out_fifo_rempty_n = 1'b1; out_fifo_rdata = (k == 0) ? 11'h355 : 11'h0AA;
      @(negedge io_clk);
      n_checks++; if (in_fifo_wenq !== 1'b1 || out_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL abort_prefix wenq=%b deq=%b want 1 1", in_fifo_wenq, out_fifo_deq); end
      @(posedge io_clk); #1;
    end
    if (use_clr) clr = 1'b1; else io_rst = 1'b1;
    @(negedge io_clk);
    n_checks++; if (out_fifo_deq !== 1'b0) begin n_fail++; $display("FAIL abort_deq got %b want 0", out_fifo_deq); end
    @(posedge io_clk); #1;
    clr = 1'b0; io_rst = 1'b0; out_fifo_rempty_n = 1'b0;
    @(negedge io_clk);
    n_checks++; if (tx_ready !== 1'b1 || in_fifo_wenq !== 1'b0 || in_fifo_wdata !== 11'h000) begin n_fail++; $display("FAIL abort_tx got ready=%b wenq=%b wdata=%h want 1 0 000", tx_ready, in_fifo_wenq, in_fifo_wdata); end
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== '0 || rx_err !== 1'b0) begin n_fail++; $display("FAIL abort_rx got v=%b data=%h err=%b want 0 0 0", rx_valid, rx_data, rx_err); end
    @(posedge io_clk); #1;
    test_tx({11'h0F0, 11'h00F, 11'h7F0, 11'h10F}, -1, 0);
    test_rx({11'h111, 11'h222, 11'h333, 11'h444}, 1);
  endtask

  initial begin
    test_reset();
    test_tx({11'h004, 11'h003, 11'h002, 11'h001}, -1, 0);
    test_tx({11'h004, 11'h003, 11'h002, 11'h001}, 2, 3);
    test_rx({11'h2AA, 11'h155, 11'h000, 11'h7FF}, 5);
    test_msb_first({11'h004, 11'h003, 11'h002, 11'h001});
    test_abort(1'b0);
    test_abort(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
